// File: rtl/wb_arb2_pkg.sv
// Shared state encoding, default widths and grant helper for the two-master Wishbone arbiter.
package wb_arb2_pkg;

  localparam int unsigned DEF_ADDR_W = 12;
  localparam int unsigned DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } state_t;

  function automatic logic [1:0] gnt_onehot(input state_t s);
    case (s)
      ST_GNT0: return 2'b01;
      ST_GNT1: return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/wb_arb2_wdog.sv
// Stall watchdog: counts strobe cycles without ack and flags expiry at TIMEOUT.
module wb_arb2_wdog #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expire_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_expire_c = i_inc && !i_clr && (r_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_cnt <= '0;
    end else if (i_clr || o_expire_c) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/wb_arb2.sv
// Two-master round-robin Wishbone arbiter onto one shared slave, no preemption.
// Optional stall watchdog selected by WB_ARB2_TIMEOUT_EN.
module wb_arb2
  import wb_arb2_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic [ADDR_W-1:0]   m0_adr_i,
  input  logic [DATA_W-1:0]   m0_dat_i,
  output logic [DATA_W-1:0]   m0_dat_o,
  input  logic                m0_we_i,
  input  logic                m0_stb_i,
  input  logic                m0_cyc_i,
  input  logic [DATA_W/8-1:0] m0_sel_i,
  output logic                m0_ack_o,
  input  logic [ADDR_W-1:0]   m1_adr_i,
  input  logic [DATA_W-1:0]   m1_dat_i,
  output logic [DATA_W-1:0]   m1_dat_o,
  input  logic                m1_we_i,
  input  logic                m1_stb_i,
  input  logic                m1_cyc_i,
  input  logic [DATA_W/8-1:0] m1_sel_i,
  output logic                m1_ack_o,
  output logic [ADDR_W-1:0]   wb_adr_o,
  output logic [DATA_W-1:0]   wb_dat_o,
  output logic                wb_we_o,
  output logic [DATA_W/8-1:0] wb_sel_o,
  output logic                wb_stb_o,
  output logic                wb_cyc_o,
  input  logic [DATA_W-1:0]   wb_dat_i,
  input  logic                wb_ack_i,
`ifdef WB_ARB2_TIMEOUT_EN
  output logic                arb_timeout_o,
`endif
  output logic [1:0]          arb_gnt_o
);

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_last;
  logic [1:0] r_gnt;
  logic       w_req0;
  logic       w_req1;
  logic       w_expire;

  // State register; grant and last-granted index follow the next state.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state <= ST_IDLE;
      r_last  <= 1'b1;
      r_gnt   <= 2'b00;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= gnt_onehot(w_state_nxt);
      if (w_state_nxt == ST_GNT0) begin
        r_last <= 1'b0;
      end else if (w_state_nxt == ST_GNT1) begin
        r_last <= 1'b1;
      end
    end
  end

  // Next state: contention goes to the master not granted last.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_req0 && w_req1) begin
          w_state_nxt = r_last ? ST_GNT0 : ST_GNT1;
        end else if (w_req0) begin
          w_state_nxt = ST_GNT0;
        end else if (w_req1) begin
          w_state_nxt = ST_GNT1;
        end
      end
      ST_GNT0: if (!m0_cyc_i || w_expire) w_state_nxt = ST_IDLE;
      ST_GNT1: if (!m1_cyc_i || w_expire) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Slave-side mux and ack steering; everything quiet while idle.
  always_comb begin
    wb_adr_o = '0;
    wb_dat_o = '0;
    wb_we_o  = 1'b0;
    wb_sel_o = '0;
    wb_stb_o = 1'b0;
    wb_cyc_o = 1'b0;
    m0_ack_o = 1'b0;
    m1_ack_o = 1'b0;
    case (r_state)
      ST_GNT0: begin
        wb_adr_o = m0_adr_i;
        wb_dat_o = m0_dat_i;
        wb_we_o  = m0_we_i;
        wb_sel_o = m0_sel_i;
        wb_stb_o = m0_stb_i;
        wb_cyc_o = m0_cyc_i;
        m0_ack_o = wb_ack_i;
      end
      ST_GNT1: begin
        wb_adr_o = m1_adr_i;
        wb_dat_o = m1_dat_i;
        wb_we_o  = m1_we_i;
        wb_sel_o = m1_sel_i;
        wb_stb_o = m1_stb_i;
        wb_cyc_o = m1_cyc_i;
        m1_ack_o = wb_ack_i;
      end
      default: ;
    endcase
  end

  assign m0_dat_o  = wb_dat_i;
  assign m1_dat_o  = wb_dat_i;
  assign arb_gnt_o = r_gnt;

`ifdef WB_ARB2_TIMEOUT_EN
  logic w_wd_clr;
  logic w_wd_inc;
  logic r_blk0;
  logic r_blk1;
  logic r_timeout;

  assign w_wd_clr = ((r_state == ST_IDLE) && (w_state_nxt != ST_IDLE)) || wb_ack_i;
  assign w_wd_inc = wb_stb_o && !wb_ack_i;

  wb_arb2_wdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .i_clr     (w_wd_clr),
    .i_inc     (w_wd_inc),
    .o_expire_c(w_expire)
  );

  // A timed-out master stays locked out until it lets go of cyc.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_blk0    <= 1'b0;
      r_blk1    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_expire;
      if (w_expire && (r_state == ST_GNT0)) begin
        r_blk0 <= 1'b1;
      end else if (!m0_cyc_i) begin
        r_blk0 <= 1'b0;
      end
      if (w_expire && (r_state == ST_GNT1)) begin
        r_blk1 <= 1'b1;
      end else if (!m1_cyc_i) begin
        r_blk1 <= 1'b0;
      end
    end
  end

  assign w_req0        = m0_cyc_i && !r_blk0;
  assign w_req1        = m1_cyc_i && !r_blk1;
  assign arb_timeout_o = r_timeout;
`else
  logic [31:0] w_unused_timeout;

  assign w_unused_timeout = 32'(TIMEOUT);
  assign w_expire         = 1'b0;
  assign w_req0           = m0_cyc_i;
  assign w_req1           = m1_cyc_i;
`endif

endmodule
